present80_dec: RTL and testbench
================================

// Module: present80_dec
// PURPOSE
//  Iterative PRESENT-80 decryption core; the inverse of the encryption datapath built around the 64-bit state register.
//  Loads a ciphertext and an 80-bit user key, runs the forward key schedule to reach K32,
//  then applies 31 inverse rounds while stepping the key schedule backwards.
//  Sits beside the encryption core; shares its start/ready handshake style and [0:63] bit order (bit 0 = MSB).
// PARAMETERS
//  NR   31  number of cipher rounds; 31 for standard PRESENT-80, smaller values for debug only
// PORTS
//  ck   in   1   rising-edge clock; the only clock
//  rst  in   1   synchronous, active-high reset
//  sta  in   1   start: sample inp and key this edge, begin decryption
//  inp  in   64  ciphertext [0:63], bit 0 = MSB
//  key  in   80  user key [0:79], bit 0 = MSB (k79)
//  out  out  64  plaintext [0:63], registered
//  rdy  out  1   high while out holds a valid result
//  bsy  out  1   high while a decryption is in progress
// BEHAVIOUR
//  Reset (rst=1 at posedge): out=0, rdy=0, bsy=0, FSM=IDLE, st=0, kr=0, cnt=0; overrides sta.
//  Internal regs: st[0:63] state, kr[0:79] key reg, cnt[4:0] round counter, FSM {IDLE,KEYS,DEC,FIN}.
//  sta (highest priority after rst, any state): st<=inp, kr<=key, cnt<=1, rdy<=0, bsy<=1, FSM<=KEYS.
//   - sta while bsy aborts the current run and restarts; out keeps its old value, rdy drops.
//  KEYS (cnt=1..NR): kr<=fwd(kr,cnt), cnt<=cnt+1; after cnt==NR, kr=K(NR+1), cnt<=NR, FSM<=DEC.
//   fwd(k,i): k=k<<<61; k[0:3]=S(k[0:3]); k[60:64]^=i (5 bits; PRESENT bits k19..k15).
//  DEC (cnt=NR..1): st<=invS(invP(st ^ kr[0:63])); kr<=inv(kr,cnt); cnt<=cnt-1.
//   inv(k,i): k[60:64]^=i; k[0:3]=invS(k[0:3]); k=k>>>61. After cnt==1: kr=K1, FSM<=FIN.
//  FIN: out<=st ^ kr[0:63]; rdy<=1; bsy<=0; FSM<=IDLE.
//  IDLE: hold out/rdy; rdy stays high until next sta or rst.
//  Latency: sta sampled at edge 0 -> rdy/out valid after edge 2*NR+1 (63 for NR=31). Throughput: 1 block / 2*NR+1 cycles.
//  invP: bit j of result = bit P(j) of input, where P(i)=16*i mod 63 (i<63), P(63)=63, PRESENT LSB-first indexing.
//  S = C56B90AD3EF84712 (hex, input 0..F); invS = 5EF8C12DB463079A.
//  cnt width 5 bits; counter never wraps (bounded 1..NR). inp/key changes while bsy are ignored.
//  bsy=1 from edge after sta through the FIN edge; rdy and bsy never both 1.
// STRUCTURE
//  present80_pkg: S/invS tables, p_layer/inv_p_layer functions, key-update functions, FSM state encoding, NR default.
//  Sub-module present80_ksched: 80-bit key register with load / fwd-step / inv-step controls and round index input.
//  Top: FSM, counter, state register, inverse round datapath, output register.
// TESTING
//  key=0, inp=5579C1387B228445, pulse sta -> after 63 cycles rdy=1, out=0000000000000000.
//  key=FFFFFFFFFFFFFFFFFFFF, inp=E72C46C0F5945049 -> out=0000000000000000.
//  key=0, inp=A112FFC72F68417B -> out=FFFFFFFFFFFFFFFF; key=all-1s, inp=3333DCD3213210D2 -> out=FFFFFFFFFFFFFFFF.
//  sta again at cycle 20 of a run with new vector -> rdy stays 0, result is for the second vector, 63 cycles after 2nd sta.
//  rst asserted mid-DEC -> next edge out=0, rdy=0, bsy=0; subsequent sta runs cleanly.
//  Back-to-back: sta on cycle rdy rises -> rdy drops next edge, out holds old value until new FIN.

Source files
------------

// File: rtl/present80_pkg.sv
// Shared PRESENT-80 tables, permutation/key-step helpers and FSM encoding.
// Vectors are held as logic [N-1:0] with the MSB at the top; that is the same value as [0:N-1] with bit 0 = MSB.
package present80_pkg;

   localparam int NR_DEFAULT = 31;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_KEYS = 2'd1;
   localparam logic [1:0] ST_DEC  = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   // Entry for input 0 sits in the top nibble.
   localparam logic [63:0] SBOX_TBL     = 64'hC56B90AD3EF84712;
   localparam logic [63:0] INV_SBOX_TBL = 64'h5EF8C12DB463079A;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [5:0] sh;
      sh = {~x, 2'b00};
      return SBOX_TBL[sh +: 4];
   endfunction

   function automatic logic [3:0] inv_sbox(input logic [3:0] x);
      logic [5:0] sh;
      sh = {~x, 2'b00};
      return INV_SBOX_TBL[sh +: 4];
   endfunction

   function automatic logic [63:0] inv_s_layer(input logic [63:0] x);
      logic [63:0] o;
      for (int n = 0; n < 16; n++) o[4*n +: 4] = inv_sbox(x[4*n +: 4]);
      return o;
   endfunction

   // Bit i moves to position 16*i mod 63; bit 63 stays put.
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] o;
      for (int i = 0; i < 63; i++) o[(16*i) % 63] = x[i];
      o[63] = x[63];
      return o;
   endfunction

   function automatic logic [63:0] inv_p_layer(input logic [63:0] x);
      logic [63:0] o;
      for (int j = 0; j < 63; j++) o[j] = x[(16*j) % 63];
      o[63] = x[63];
      return o;
   endfunction

   function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] i);
      logic [79:0] r;
      r = {k[18:0], k[79:19]};
      r[79:76] = sbox(r[79:76]);
      r[19:15] = r[19:15] ^ i;
      return r;
   endfunction

   // Exact undo of key_fwd: xor, inverse S-box, then rotate right by 61.
   function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] i);
      logic [79:0] r;
      r = k;
      r[19:15] = r[19:15] ^ i;
      r[79:76] = inv_sbox(r[79:76]);
      return {r[60:0], r[79:61]};
   endfunction

endpackage

// File: rtl/present80_ksched.sv
// 80-bit PRESENT key register stepping forwards or backwards by round index.
module present80_ksched
   import present80_pkg::*;
(
   input  logic        ck,
   input  logic        rst,
   input  logic        ld,
   input  logic        fwd,
   input  logic        inv,
   input  logic [4:0]  rnd,
   input  logic [79:0] key,
   output logic [63:0] rk
);

   logic [79:0] kr_d, kr_q;

   always_comb begin
      kr_d = kr_q;
      if (ld)       kr_d = key;
      else if (fwd) kr_d = key_fwd(kr_q, rnd);
      else if (inv) kr_d = key_inv(kr_q, rnd);
   end

   always_ff @(posedge ck) begin
      if (rst) kr_q <= '0;
      else     kr_q <= kr_d;
   end

   assign rk = kr_q[79:16];

endmodule

// File: rtl/present80_dec.sv
// Iterative PRESENT-80 decryption: forward key walk to K(NR+1), then NR inverse rounds.
module present80_dec
   import present80_pkg::*;
#(
   parameter int NR = NR_DEFAULT
) (
   input  logic        ck,
   input  logic        rst,
   input  logic        sta,
   input  logic [63:0] inp,
   input  logic [79:0] key,
   output logic [63:0] out,
   output logic        rdy,
   output logic        bsy
);

   localparam logic [4:0] NR5 = 5'(NR);

   logic [1:0]  fsm_d, fsm_q;
   logic [4:0]  cnt_d, cnt_q;
   logic [63:0] st_d, st_q;
   logic [63:0] out_d, out_q;
   logic        rdy_d, rdy_q;
   logic        bsy_d, bsy_q;
   logic [63:0] rk;

   present80_ksched u_ksched (
      .ck  (ck),
      .rst (rst),
      .ld  (sta),
      .fwd (fsm_q == ST_KEYS),
      .inv (fsm_q == ST_DEC),
      .rnd (cnt_q),
      .key (key),
      .rk  (rk)
   );

   always_comb begin
      fsm_d = fsm_q;
      cnt_d = cnt_q;
      st_d  = st_q;
      out_d = out_q;
      rdy_d = rdy_q;
      bsy_d = bsy_q;
      // A start restarts from any state; out keeps the previous result.
      if (sta) begin
         st_d  = inp;
         cnt_d = 5'd1;
         rdy_d = 1'b0;
         bsy_d = 1'b1;
         fsm_d = ST_KEYS;
      end else begin
         case (fsm_q)
            ST_KEYS: begin
               if (cnt_q == NR5) fsm_d = ST_DEC;
               else              cnt_d = cnt_q + 5'd1;
            end
            ST_DEC: begin
               st_d = inv_s_layer(inv_p_layer(st_q ^ rk));
               if (cnt_q == 5'd1) fsm_d = ST_FIN;
               else               cnt_d = cnt_q - 5'd1;
            end
            ST_FIN: begin
               out_d = st_q ^ rk;
               rdy_d = 1'b1;
               bsy_d = 1'b0;
               fsm_d = ST_IDLE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         fsm_q <= ST_IDLE;
         cnt_q <= '0;
         st_q  <= '0;
         out_q <= '0;
         rdy_q <= 1'b0;
         bsy_q <= 1'b0;
      end else begin
         fsm_q <= fsm_d;
         cnt_q <= cnt_d;
         st_q  <= st_d;
         out_q <= out_d;
         rdy_q <= rdy_d;
         bsy_q <= bsy_d;
      end
   end

   assign out = out_q;
   assign rdy = rdy_q;
   assign bsy = bsy_q;

endmodule

// File: tb/tb_present80_dec.sv
// Bench for present80_dec: known-answer table, model-generated vectors, abort/reset/back-to-back cases.
module tb_present80_dec;

   localparam int LAT = 63;

   logic        ck = 1'b0;
   logic        rst, sta;
   logic [63:0] inp, out;
   logic [79:0] key;
   logic        rdy, bsy;

   present80_dec #(.NR(31)) dut (
      .ck(ck), .rst(rst), .sta(sta), .inp(inp), .key(key),
      .out(out), .rdy(rdy), .bsy(bsy)
   );

   always #5 ck = ~ck;

   typedef struct {
      logic [63:0] ct;
      logic [79:0] k;
      logic [63:0] pt;
   } vec_t;

   localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                      4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q [$];
   logic [63:0] last_out;

   // Forward PRESENT-80 encryption, used to make fresh ciphertexts for the decryptor.
   function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] k_in);
      logic [63:0] s, t;
      logic [79:0] k;
      s = pt;
      k = k_in;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
         for (int b = 0; b < 63; b++) s[(16*b) % 63] = t[b];
         s[63] = t[63];
         k = {k[18:0], k[79:19]};
         k[79:76] = SB[k[79:76]];
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return s ^ k[79:16];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Caller sits at a negedge; sta is sampled on the following posedge.
   task automatic start_vec(input vec_t v);
      sta = 1'b1;
      inp = v.ct;
      key = v.k;
      exp_q.push_back(v.pt);
      @(negedge ck);
      sta = 1'b0;
      inp = ~v.ct;
      key = ~v.k;
      chk("start_bsy", 64'(bsy), 64'd1);
      chk("start_rdy", 64'(rdy), 64'd0);
      chk("start_out_hold", out, last_out);
   endtask

   task automatic wait_result(input string name);
      int   n;
      logic seen, both;
      logic [63:0] e;
      seen = 1'b0;
      both = 1'b0;
      n = 0;
      while (!seen && n < 200) begin
         @(negedge ck);
         n++;
         if (rdy && bsy) both = 1'b1;
         if (rdy) seen = 1'b1;
      end
      chk({name, "_rdy_bsy_excl"}, 64'(both), 64'd0);
      chk({name, "_latency"}, 64'(n), 64'(LAT));
      if (seen) begin
         chk({name, "_bsy_done"}, 64'(bsy), 64'd0);
         if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            chk({name, "_out"}, out, e);
            last_out = e;
         end
      end
   endtask

   vec_t tbl [7];

   initial begin
      vec_t va, vb;
      logic any_rdy;
      logic [63:0] p;
      logic [79:0] k;

      tbl[0] = '{64'h5579C1387B228445, 80'h0,                     64'h0};
      tbl[1] = '{64'hE72C46C0F5945049, 80'hFFFFFFFFFFFFFFFFFFFF,  64'h0};
      tbl[2] = '{64'hA112FFC72F68417B, 80'h0,                     64'hFFFFFFFFFFFFFFFF};
      tbl[3] = '{64'h3333DCD3213210D2, 80'hFFFFFFFFFFFFFFFFFFFF,  64'hFFFFFFFFFFFFFFFF};
      for (int i = 4; i < 7; i++) begin
         p = {$urandom, $urandom};
         k = {16'($urandom), $urandom, $urandom};
         tbl[i] = '{enc(p, k), k, p};
      end

      rst = 1'b1; sta = 1'b1; inp = '1; key = '1;
      repeat (2) @(negedge ck);
      chk("reset_out", out, 64'h0);
      chk("reset_rdy", 64'(rdy), 64'd0);
      chk("reset_bsy", 64'(bsy), 64'd0);
      rst = 1'b0; sta = 1'b0;
      last_out = '0;
      @(negedge ck);

      // Table vectors, run back to back: each start lands in the cycle rdy rose.
      for (int i = 0; i < 7; i++) begin
         start_vec(tbl[i]);
         wait_result($sformatf("vec%0d", i));
      end

      // Result and rdy hold while idle.
      repeat (3) @(negedge ck);
      chk("idle_rdy", 64'(rdy), 64'd1);
      chk("idle_out", out, last_out);

      // Restart 20 cycles into a run: only the second vector's result appears.
      va = tbl[2];
      vb = tbl[1];
      start_vec(va);
      any_rdy = 1'b0;
      repeat (19) begin
         @(negedge ck);
         if (rdy) any_rdy = 1'b1;
      end
      exp_q.delete();
      start_vec(vb);
      chk("abort_no_rdy", 64'(any_rdy), 64'd0);
      wait_result("abort");

      // Reset during the inverse rounds clears everything.
      start_vec(tbl[3]);
      repeat (40) @(negedge ck);
      rst = 1'b1;
      @(negedge ck);
      rst = 1'b0;
      chk("midrst_out", out, 64'h0);
      chk("midrst_rdy", 64'(rdy), 64'd0);
      chk("midrst_bsy", 64'(bsy), 64'd0);
      exp_q.delete();
      last_out = '0;
      @(negedge ck);
      start_vec(tbl[0]);
      wait_result("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
